// File: rtl/detect_seq_ctrl.sv
// detect_seq_ctrl: trains the pixel cell array, streams detect frames and counts changed pixels; DETECT_BBOX_EN adds bounding-box outputs
module detect_seq_ctrl #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 11
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start_train,
  input  logic              i_start_detect,
  input  logic              i_pix_valid,
  input  logic [7:0]        i_pix_data,
  output logic              o_pix_ready,
  input  logic [7:0]        i_pix_tol,
  input  logic [CNT_W-1:0]  i_cnt_thresh,
  output logic              o_cell_mode,
  output logic              o_cell_wr,
  output logic [ADDR_W-1:0] o_cell_addr,
  output logic [7:0]        o_cell_data,
  input  logic [7:0]        i_cell_diff,
  input  logic              i_cell_diff_valid,
  output logic              o_trained,
  output logic              o_busy,
  output logic              o_err_untrained,
  output logic              o_result_valid,
  output logic              o_object_detected,
  output logic [CNT_W-1:0]  o_change_count
`ifdef DETECT_BBOX_EN
  ,
  output logic [ADDR_W-1:0] o_bbox_xmin,
  output logic [ADDR_W-1:0] o_bbox_xmax,
  output logic [ADDR_W-1:0] o_bbox_ymin,
  output logic [ADDR_W-1:0] o_bbox_ymax,
  output logic              o_bbox_valid
`endif
);
  localparam int N  = IMG_W * IMG_H;
  localparam int IW = ADDR_W + 1;
  localparam logic [IW-1:0] N_END  = IW'(N);
  localparam logic [IW-1:0] N_LAST = IW'(N - 1);
  typedef enum logic [2:0] {IDLE, TRAIN, DETECT, DRAIN, RESULT} state_t;
  state_t           state, state_nx;
  logic [IW-1:0]    pix_idx, res_idx;
  logic [CNT_W-1:0] chg_cnt;
  logic             accept, res_take, hit, go_train, go_detect;
  assign o_pix_ready = state == TRAIN || state == DETECT;
  assign accept      = i_pix_valid && o_pix_ready;
  assign res_take    = (state == DETECT || state == DRAIN) && i_cell_diff_valid && res_idx != N_END;
  assign hit         = res_take && i_cell_diff >= i_pix_tol;
  assign go_train    = state == IDLE && i_start_train;
  assign go_detect   = state == IDLE && !i_start_train && i_start_detect && o_trained;
  // next-state selection and state-decoded status outputs
  always_comb begin
    state_nx       = state;
    o_busy         = state != IDLE;
    o_result_valid = state == RESULT;
    case (state)
      IDLE:    state_nx = go_train ? TRAIN : go_detect ? DETECT : IDLE;
      TRAIN:   state_nx = accept && pix_idx == N_LAST ? IDLE : TRAIN;
      DETECT:  state_nx = accept && pix_idx == N_LAST ? DRAIN : DETECT;
      DRAIN:   state_nx = res_idx == N_END ? RESULT : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  // state register and registered cell write port; mode lags state so the last train write keeps mode 0
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      pix_idx     <= '0;
      o_cell_wr   <= 1'b0;
      o_cell_addr <= '0;
      o_cell_data <= '0;
      o_cell_mode <= 1'b1;
    end else begin
      state       <= state_nx;
      pix_idx     <= state == IDLE ? '0 : accept && pix_idx != N_END ? pix_idx + IW'(1) : pix_idx;
      o_cell_wr   <= accept;
      o_cell_addr <= accept ? pix_idx[ADDR_W-1:0] : o_cell_addr;
      o_cell_data <= accept ? i_pix_data : o_cell_data;
      o_cell_mode <= state != TRAIN;
    end
  end
  // training status, error pulse, result counting and latched frame result
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_trained         <= 1'b0;
      o_err_untrained   <= 1'b0;
      res_idx           <= '0;
      chg_cnt           <= '0;
      o_change_count    <= '0;
      o_object_detected <= 1'b0;
    end else begin
      o_err_untrained <= state == IDLE && !i_start_train && i_start_detect && !o_trained;
      o_trained       <= go_train ? 1'b0 : o_cell_wr && !o_cell_mode && o_cell_addr == ADDR_W'(N - 1) ? 1'b1 : o_trained;
      res_idx         <= go_detect ? '0 : res_take ? res_idx + IW'(1) : res_idx;
      chg_cnt         <= go_detect ? '0 : hit && chg_cnt != '1 ? chg_cnt + CNT_W'(1) : chg_cnt;
      if (state_nx == RESULT) begin
        o_change_count    <= chg_cnt;
        o_object_detected <= chg_cnt >= i_cnt_thresh;
      end
    end
  end
`ifdef DETECT_BBOX_EN
  logic [ADDR_W-1:0] col, row, xmin, xmax, ymin, ymax;
  logic              col_last;
  assign col_last = col == ADDR_W'(IMG_W - 1);
  // running column/row of the next result and extents of counted changes, latched with the frame result
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      col          <= '0;
      row          <= '0;
      xmin         <= '0;
      xmax         <= '0;
      ymin         <= '0;
      ymax         <= '0;
      o_bbox_xmin  <= '0;
      o_bbox_xmax  <= '0;
      o_bbox_ymin  <= '0;
      o_bbox_ymax  <= '0;
      o_bbox_valid <= 1'b0;
    end else begin
      if (go_detect) begin
        col  <= '0;
        row  <= '0;
        xmin <= ADDR_W'(IMG_W - 1);
        xmax <= '0;
        ymin <= ADDR_W'(IMG_H - 1);
        ymax <= '0;
      end else begin
        if (res_take) begin
          col <= col_last ? '0 : col + ADDR_W'(1);
          row <= col_last ? row + ADDR_W'(1) : row;
        end
        if (hit) begin
          xmin <= col < xmin ? col : xmin;
          xmax <= col > xmax ? col : xmax;
          ymin <= row < ymin ? row : ymin;
          ymax <= row > ymax ? row : ymax;
        end
      end
      if (state_nx == RESULT) begin
        o_bbox_xmin  <= xmin;
        o_bbox_xmax  <= xmax;
        o_bbox_ymin  <= ymin;
        o_bbox_ymax  <= ymax;
        o_bbox_valid <= chg_cnt != '0;
      end
    end
  end
`endif
endmodule

// File: doc/detect_seq_ctrl.md
Name: detect_seq_ctrl

Overview:
- Sequencer for the pixel memory-cell array of the object detector.
- Streams a training (background) frame into the cells, then streams live frames in detect mode.
- Collects the per-pixel XOR differences the cells return and counts pixels whose difference meets a tolerance.
- Flags an object when the changed-pixel count reaches a threshold.

Parameters:
IMG_W, 32, image width in pixels
IMG_H, 32, image height in pixels
ADDR_W, 10, pixel address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
CNT_W, 11, changed-pixel counter width; holds 0..IMG_W*IMG_H

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_start_train  in  1  one-cycle pulse; begin training frame
i_start_detect  in  1  one-cycle pulse; begin detect frame
i_pix_valid  in  1  input pixel valid
i_pix_data  in  8  input pixel
o_pix_ready  out  1  controller accepts pixel this cycle
i_pix_tol  in  8  per-pixel XOR tolerance
i_cnt_thresh  in  CNT_W  changed-pixel count for detection
o_cell_mode  out  1  0 = train, 1 = detect
o_cell_wr  out  1  cell write strobe
o_cell_addr  out  ADDR_W  target cell index
o_cell_data  out  8  pixel to cell
i_cell_diff  in  8  XOR result from addressed cell
i_cell_diff_valid  in  1  result valid; results return in write order
o_trained  out  1  background frame loaded
o_busy  out  1  state != IDLE
o_err_untrained  out  1  one-cycle pulse; detect requested before training
o_result_valid  out  1  one-cycle pulse; frame result ready
o_object_detected  out  1  latched result of last detect frame
o_change_count  out  CNT_W  latched changed-pixel count

Behaviour:
- Reset: state IDLE; every output 0 except o_cell_mode = 1; all counters cleared. Reset mid-frame aborts immediately and clears o_trained.
- States: IDLE, TRAIN, DETECT, DRAIN, RESULT.
- IDLE:
  - i_start_train goes to TRAIN.
  - i_start_detect with o_trained=1 goes to DETECT.
  - i_start_detect with o_trained=0 pulses o_err_untrained next cycle and stays in IDLE.
  - Both starts in the same cycle: train wins.
- Starts received outside IDLE are ignored.
- o_pix_ready = 1 only in TRAIN and DETECT. A pixel is accepted on i_pix_valid & o_pix_ready.
- Registered cell outputs, 1-cycle latency from acceptance:
  - o_cell_wr = 1.
  - o_cell_data = pixel.
  - o_cell_addr = pixel index, 0..N-1 where N = IMG_W*IMG_H.
- o_cell_mode:
  - 0 throughout TRAIN.
  - 1 in all other states.
  - Changes only on state entry, never together with a write of the other mode.
- TRAIN:
  - After pixel N-1 is accepted: o_trained = 1 in the cycle after the last write; go to IDLE. No result pulse.
  - Retraining overwrites the background.
  - o_trained is cleared on entering TRAIN and set again at its end.
- DETECT:
  - Clear the change counter and result index on entry.
  - After pixel N-1 is accepted, go to DRAIN.
- Result counting, active in DETECT and DRAIN:
  - On each i_cell_diff_valid, increment the result index.
  - If i_cell_diff >= i_pix_tol, also increment the change counter, saturating at all-ones.
  - i_pix_tol = 0 counts every pixel.
  - i_cell_diff_valid is ignored in IDLE, TRAIN and RESULT.
- DRAIN: wait until the result index reaches N, then go to RESULT.
- RESULT (one cycle):
  - o_result_valid = 1.
  - o_change_count = counter value.
  - o_object_detected = (count >= i_cnt_thresh).
  - Go to IDLE.
  - Latched outputs hold until the next RESULT or reset.
- Pixel-index and result-index counters stop at N; they do not wrap.

Optional Feature:
- Macro: DETECT_BBOX_EN.
- When defined, adds outputs:
  - o_bbox_xmin, o_bbox_xmax: ADDR_W bits each.
  - o_bbox_ymin, o_bbox_ymax: ADDR_W bits each.
  - o_bbox_valid: 1 bit.
- Bounding-box tracking:
  - Each counted change, at result index → x = idx % IMG_W, y = idx / IMG_W, tracked as running column/row counters, no divider.
  - Min/max per axis update on each counted change.
  - Min/max reset to (IMG_W-1, 0, IMG_H-1, 0) on DETECT entry.
  - Values latch at RESULT.
  - o_bbox_valid = (count > 0).
- When not defined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset, then i_start_detect → o_err_untrained pulses once; state stays IDLE; no o_cell_wr.
- Train with a 4x4 image (IMG_W=IMG_H=4), all pixels 0x10 → 16 writes at addr 0..15 with mode=0; o_trained=1 after the last write; no o_result_valid.
- Detect with an identical frame, i_cnt_thresh=1 → o_change_count=0; o_object_detected=0; one o_result_valid pulse.
- Detect with pixels 5, 6, 9 at 0xF0, i_pix_tol=0x20, i_cnt_thresh=3 → count=3, detected=1. With DETECT_BBOX_EN: x 1..2, y 1..2, o_bbox_valid=1.
- Toggle i_pix_valid randomly with i_cell_diff_valid delayed 3 cycles → DRAIN waits; result still appears only after 16 diffs.
- i_start_train and i_start_detect together in IDLE → TRAIN entered. Reset asserted mid-DETECT → IDLE, o_trained=0, outputs cleared.
